yarp_fetch: RTL and testbench
=============================

Name: yarp_fetch

Overview:
- Instruction fetch stage that sits directly upstream of the decode stage.
- Owns the fetch PC and issues single-outstanding requests on the instruction-memory req/gnt/rvalid interface.
- Holds each returned instruction word and its PC in an output register until decode accepts it with a valid/ready handshake.
- Accepts redirects (branch/jump/trap targets) at any time and discards stale in-flight data.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address used for the first request after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- imem_req_o  output  1  instruction-memory request valid.
- imem_addr_o  output  32  request address; bits [1:0] always 0.
- imem_gnt_i  input  1  request accepted this cycle (req and gnt both high).
- imem_rvalid_i  input  1  response data valid.
- imem_rdata_i  input  32  response instruction word.
- redirect_i  input  1  single-cycle pulse that loads a new fetch PC.
- redirect_pc_i  input  32  redirect target; bits [1:0] are ignored and treated as 0.
- instr_valid_o  output  1  instr_o and pc_o hold a valid instruction for decode.
- instr_ready_i  input  1  decode accepts the instruction this cycle.
- instr_o  output  32  instruction word, fed to the decode stage's instr_i.
- pc_o  output  32  address of instr_o.

Behaviour:
- Reset (asynchronous, while reset_n=0):
  - state=IDLE, fetch_pc=RESET_PC, instr_valid_o=0, instr_o=0, pc_o=RESET_PC, imem_req_o=0.
- States: IDLE, REQ, WAIT, HOLD, DROP.
- IDLE: imem_req_o=0. Goes to REQ on the first clock after reset release.
- REQ: imem_req_o=1, imem_addr_o=fetch_pc.
  - gnt=1: go to WAIT.
  - gnt=0: stay in REQ with the address held stable.
- WAIT: imem_req_o=0.
  - On rvalid: instr_o<=rdata, pc_o<=fetch_pc, instr_valid_o<=1, fetch_pc<=fetch_pc+4. Go to HOLD.
- HOLD: instr_valid_o=1; instr_o and pc_o are stable.
  - On instr_ready_i: instr_valid_o<=0, go to REQ.
  - Throughput: at most one instruction per 3 cycles with zero-wait memory.
- DROP: imem_req_o=0. Wait for rvalid, discard the data, then go to REQ.
- Memory protocol:
  - rvalid arrives no earlier than the cycle after gnt. rvalid is never asserted without an outstanding request.
  - At most one request is ever outstanding.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 32'h0000_0000.
- Latency: instr_valid_o rises in the cycle after rvalid. Best case req→instr_valid_o is 2 cycles (gnt in cycle 0, rvalid in cycle 1, valid in cycle 2).
- Redirect (fetch_pc<={redirect_pc_i[31:2],2'b00}; instr_valid_o<=0 unless noted):
  - IDLE: fetch_pc updated; proceed to REQ.
  - REQ, gnt=0: next state REQ with the new address. The old request is withdrawn without being accepted.
  - REQ, gnt=1 same cycle: the old request was accepted; go to DROP.
  - WAIT, no rvalid: go to DROP.
  - WAIT with rvalid same cycle: data discarded; go to REQ; fetch_pc is not incremented.
  - HOLD: buffered instruction discarded; go to REQ. If instr_ready_i is high in the same cycle, the handshake counts as completed (decode consumed it), then the redirect applies.
  - DROP: fetch_pc updated; remain in DROP until rvalid.
  - Back-to-back redirects: the last one wins.
- Reset mid-operation: all outputs return to reset values immediately. An outstanding memory response after reset release is not expected; the memory side is reset together with the core.
- instr_o and pc_o change only on capture in WAIT; they retain their value when instr_valid_o=0.

Test Plan:
- Reset release, RESET_PC=0, zero-wait memory (gnt with req, rvalid next cycle), ready tied high → addresses 0x0,0x4,0x8 requested; instr_o/pc_o sequence matches memory words; instr_valid_o high 1 of every 3 cycles.
- gnt delayed 3 cycles, rvalid delayed 2 cycles after gnt → imem_addr_o held stable while req=1; exactly one outstanding request; correct instr/pc.
- Backpressure: ready low 5 cycles in HOLD → instr_o/pc_o/valid stable; no new imem_req_o until ready=1.
- Redirect to 0x0000_0103 while in WAIT → rvalid data dropped (instr_valid_o stays 0); next request address 0x0000_0100; delivered pc_o=0x100.
- Redirect in same cycle as gnt, and redirect coincident with rvalid → the first goes via DROP; neither delivers stale data; next request at the target.
- RESET_PC=32'hFFFF_FFFC → second request address 32'h0000_0000. Assert reset_n=0 mid-WAIT → imem_req_o=0 and instr_valid_o=0 asynchronously.

Source files
------------

// File: rtl/yarp_fetch_if.sv
// Bundles the instruction-memory request bus and the fetch-to-decode handshake.
interface yarp_fetch_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  modport master (
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
           redirect_i, redirect_pc_i, instr_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
           redirect_i, redirect_pc_i, instr_ready_i
  );
endinterface

// File: rtl/yarp_fetch.sv
// Fetch stage: single-outstanding instruction-memory requests, one-entry output
// buffer towards decode, and redirect handling that discards stale responses.
module yarp_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset_n,
  yarp_fetch_if.master bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DROP = 3'd4
  } state_t;

  state_t      state_q;
  logic [31:0] fetch_pc_q;
  logic        req_q;
  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] redirect_tgt_d;

  assign redirect_tgt_d = bus.redirect_pc_i & 32'hFFFF_FFFC;

  // req_q/valid_q are set on entry to REQ/HOLD so outputs come straight from flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC & 32'hFFFF_FFFC;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= 32'h0000_0000;
      pc_q       <= RESET_PC;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.redirect_i) fetch_pc_q <= redirect_tgt_d;
          state_q <= REQ;
          req_q   <= 1'b1;
        end

        REQ: begin
          if (bus.redirect_i) begin
            fetch_pc_q <= redirect_tgt_d;
            if (bus.imem_gnt_i) begin
              // Old address was already accepted; its response must be swallowed.
              state_q <= DROP;
              req_q   <= 1'b0;
            end
          end else if (bus.imem_gnt_i) begin
            state_q <= WAIT;
            req_q   <= 1'b0;
          end
        end

        WAIT: begin
          if (bus.redirect_i) begin
            fetch_pc_q <= redirect_tgt_d;
            if (bus.imem_rvalid_i) begin
              state_q <= REQ;
              req_q   <= 1'b1;
            end else begin
              state_q <= DROP;
            end
          end else if (bus.imem_rvalid_i) begin
            instr_q    <= bus.imem_rdata_i;
            pc_q       <= fetch_pc_q;
            valid_q    <= 1'b1;
            fetch_pc_q <= fetch_pc_q + 32'd4;
            state_q    <= HOLD;
          end
        end

        HOLD: begin
          if (bus.redirect_i) begin
            fetch_pc_q <= redirect_tgt_d;
            valid_q    <= 1'b0;
            state_q    <= REQ;
            req_q      <= 1'b1;
          end else if (bus.instr_ready_i) begin
            valid_q <= 1'b0;
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end

        DROP: begin
          if (bus.redirect_i) fetch_pc_q <= redirect_tgt_d;
          if (bus.imem_rvalid_i) begin
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req_o    = req_q;
  assign bus.imem_addr_o   = fetch_pc_q;
  assign bus.instr_valid_o = valid_q;
  assign bus.instr_o       = instr_q;
  assign bus.pc_o          = pc_q;

endmodule

// File: tb/tb_yarp_fetch.sv
// Directed bench for yarp_fetch: the bench plays the instruction memory cycle by cycle.
module tb_yarp_fetch;

  logic clk;
  logic rsta_n;
  logic rstb_n;
  int   tests;
  int   failed;

  yarp_fetch_if ifa ();
  yarp_fetch_if ifb ();

  yarp_fetch #(.RESET_PC(32'h0000_0000)) dut_a (.clk(clk), .reset_n(rsta_n), .bus(ifa));
  yarp_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_b (.clk(clk), .reset_n(rstb_n), .bus(ifb));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Zero-wait fetch on dut_a with ready high: entered in REQ, leaves in the next REQ.
  task automatic zw_fetch(input logic [31:0] a, input logic [31:0] w);
    chk1 ("zw_req", ifa.imem_req_o, 1'b1);
    chk32("zw_addr", ifa.imem_addr_o, a);
    chk1 ("zw_valid_pre", ifa.instr_valid_o, 1'b0);
    ifa.imem_gnt_i = 1'b1;
    tick();
    chk1 ("zw_req_wait", ifa.imem_req_o, 1'b0);
    chk1 ("zw_valid_wait", ifa.instr_valid_o, 1'b0);
    ifa.imem_gnt_i    = 1'b0;
    ifa.imem_rvalid_i = 1'b1;
    ifa.imem_rdata_i  = w;
    tick();
    ifa.imem_rvalid_i = 1'b0;
    chk1 ("zw_valid", ifa.instr_valid_o, 1'b1);
    chk32("zw_instr", ifa.instr_o, w);
    chk32("zw_pc", ifa.pc_o, a);
    chk1 ("zw_req_hold", ifa.imem_req_o, 1'b0);
    tick();
    $display("[TB] fetch addr=%h instr=%h", a, w);
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rsta_n = 1'b1;
    rstb_n = 1'b1;
    ifa.imem_gnt_i = 1'b0; ifa.imem_rvalid_i = 1'b0; ifa.imem_rdata_i = 32'h0;
    ifa.redirect_i = 1'b0; ifa.redirect_pc_i = 32'h0; ifa.instr_ready_i = 1'b1;
    ifb.imem_gnt_i = 1'b0; ifb.imem_rvalid_i = 1'b0; ifb.imem_rdata_i = 32'h0;
    ifb.redirect_i = 1'b0; ifb.redirect_pc_i = 32'h0; ifb.instr_ready_i = 1'b1;
    #1;
    rsta_n = 1'b0;
    rstb_n = 1'b0;
    tick();

    // Reset state
    chk1 ("rst_req", ifa.imem_req_o, 1'b0);
    chk1 ("rst_valid", ifa.instr_valid_o, 1'b0);
    chk32("rst_instr", ifa.instr_o, 32'h0);
    chk32("rst_pc", ifa.pc_o, 32'h0);
    chk32("rst_addr", ifa.imem_addr_o, 32'h0);
    $display("[TB] reset state checked");
    tick();
    rsta_n = 1'b1;
    tick();

    // Zero-wait memory, ready high: one instruction every three cycles
    zw_fetch(32'h0000_0000, 32'h0010_0093);
    zw_fetch(32'h0000_0004, 32'h0020_0113);
    zw_fetch(32'h0000_0008, 32'h0030_0193);

    // gnt three cycles late, rvalid two cycles after gnt
    for (int i = 0; i < 3; i++) begin
      chk1 ("slow_req", ifa.imem_req_o, 1'b1);
      chk32("slow_addr", ifa.imem_addr_o, 32'h0000_000C);
      tick();
    end
    chk32("slow_addr_gnt", ifa.imem_addr_o, 32'h0000_000C);
    ifa.imem_gnt_i = 1'b1;
    tick();
    ifa.imem_gnt_i = 1'b0;
    chk1 ("slow_req_wait1", ifa.imem_req_o, 1'b0);
    tick();
    chk1 ("slow_req_wait2", ifa.imem_req_o, 1'b0);
    chk1 ("slow_valid_wait", ifa.instr_valid_o, 1'b0);
    ifa.imem_rvalid_i = 1'b1;
    ifa.imem_rdata_i  = 32'h0040_0213;
    tick();
    ifa.imem_rvalid_i = 1'b0;
    chk1 ("slow_valid", ifa.instr_valid_o, 1'b1);
    chk32("slow_instr", ifa.instr_o, 32'h0040_0213);
    chk32("slow_pc", ifa.pc_o, 32'h0000_000C);
    tick();
    $display("[TB] slow fetch addr=0000000c");

    // Backpressure: ready low for five cycles in HOLD
    chk32("bp_addr", ifa.imem_addr_o, 32'h0000_0010);
    ifa.imem_gnt_i = 1'b1;
    tick();
    ifa.imem_gnt_i    = 1'b0;
    ifa.imem_rvalid_i = 1'b1;
    ifa.imem_rdata_i  = 32'h0050_0293;
    ifa.instr_ready_i = 1'b0;
    tick();
    ifa.imem_rvalid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk1 ("bp_valid", ifa.instr_valid_o, 1'b1);
      chk32("bp_instr", ifa.instr_o, 32'h0050_0293);
      chk32("bp_pc", ifa.pc_o, 32'h0000_0010);
      chk1 ("bp_noreq", ifa.imem_req_o, 1'b0);
      tick();
    end
    ifa.instr_ready_i = 1'b1;
    tick();
    chk1 ("bp_released_valid", ifa.instr_valid_o, 1'b0);
    chk1 ("bp_released_req", ifa.imem_req_o, 1'b1);
    chk32("bp_released_addr", ifa.imem_addr_o, 32'h0000_0014);
    $display("[TB] backpressure held 5 cycles");

    // Redirect to 0x103 while in WAIT: response dropped, refetch at 0x100
    ifa.imem_gnt_i = 1'b1;
    tick();
    ifa.imem_gnt_i    = 1'b0;
    ifa.redirect_i    = 1'b1;
    ifa.redirect_pc_i = 32'h0000_0103;
    tick();
    ifa.redirect_i = 1'b0;
    chk1 ("rw_drop_req", ifa.imem_req_o, 1'b0);
    ifa.imem_rvalid_i = 1'b1;
    ifa.imem_rdata_i  = 32'hDEAD_BEEF;
    tick();
    ifa.imem_rvalid_i = 1'b0;
    chk1 ("rw_valid", ifa.instr_valid_o, 1'b0);
    chk32("rw_instr_kept", ifa.instr_o, 32'h0050_0293);
    $display("[TB] redirect in WAIT to 00000103");
    zw_fetch(32'h0000_0100, 32'h0060_0313);

    // Redirect in the same cycle as gnt: goes through DROP
    ifa.imem_gnt_i    = 1'b1;
    ifa.redirect_i    = 1'b1;
    ifa.redirect_pc_i = 32'h0000_0200;
    tick();
    ifa.imem_gnt_i = 1'b0;
    ifa.redirect_i = 1'b0;
    chk1 ("rg_req", ifa.imem_req_o, 1'b0);
    tick();
    chk1 ("rg_still_drop", ifa.imem_req_o, 1'b0);
    ifa.imem_rvalid_i = 1'b1;
    ifa.imem_rdata_i  = 32'hBAD0_0001;
    tick();
    ifa.imem_rvalid_i = 1'b0;
    chk1 ("rg_valid", ifa.instr_valid_o, 1'b0);
    chk1 ("rg_req_new", ifa.imem_req_o, 1'b1);
    chk32("rg_addr", ifa.imem_addr_o, 32'h0000_0200);
    $display("[TB] redirect with gnt to 00000200");

    // Redirect coincident with rvalid: straight back to REQ at target
    ifa.imem_gnt_i = 1'b1;
    tick();
    ifa.imem_gnt_i    = 1'b0;
    ifa.imem_rvalid_i = 1'b1;
    ifa.imem_rdata_i  = 32'hBAD0_0002;
    ifa.redirect_i    = 1'b1;
    ifa.redirect_pc_i = 32'h0000_0300;
    tick();
    ifa.imem_rvalid_i = 1'b0;
    ifa.redirect_i    = 1'b0;
    chk1 ("rr_valid", ifa.instr_valid_o, 1'b0);
    chk32("rr_instr_kept", ifa.instr_o, 32'h0060_0313);
    $display("[TB] redirect with rvalid to 00000300");
    zw_fetch(32'h0000_0300, 32'h0070_0393);

    // Redirect in REQ without gnt: request withdrawn, new address next cycle
    ifa.redirect_i    = 1'b1;
    ifa.redirect_pc_i = 32'h0000_0400;
    tick();
    ifa.redirect_i = 1'b0;
    chk1 ("rq_req", ifa.imem_req_o, 1'b1);
    chk32("rq_addr", ifa.imem_addr_o, 32'h0000_0400);
    $display("[TB] redirect in REQ to 00000400");

    // Redirect while an instruction is held
    ifa.imem_gnt_i = 1'b1;
    tick();
    ifa.imem_gnt_i    = 1'b0;
    ifa.imem_rvalid_i = 1'b1;
    ifa.imem_rdata_i  = 32'h0080_0413;
    ifa.instr_ready_i = 1'b0;
    tick();
    ifa.imem_rvalid_i = 1'b0;
    chk1 ("rh_valid", ifa.instr_valid_o, 1'b1);
    chk32("rh_pc", ifa.pc_o, 32'h0000_0400);
    ifa.redirect_i    = 1'b1;
    ifa.redirect_pc_i = 32'h0000_0504;
    tick();
    ifa.redirect_i    = 1'b0;
    ifa.instr_ready_i = 1'b1;
    chk1 ("rh_valid_cleared", ifa.instr_valid_o, 1'b0);
    chk32("rh_addr", ifa.imem_addr_o, 32'h0000_0504);
    chk32("rh_pc_kept", ifa.pc_o, 32'h0000_0400);
    $display("[TB] redirect in HOLD to 00000504");

    // Asynchronous reset in the middle of WAIT
    ifa.imem_gnt_i = 1'b1;
    tick();
    ifa.imem_gnt_i = 1'b0;
    chk1 ("ar_req_wait", ifa.imem_req_o, 1'b0);
    #2;
    rsta_n = 1'b0;
    #1;
    chk1 ("ar_req", ifa.imem_req_o, 1'b0);
    chk1 ("ar_valid", ifa.instr_valid_o, 1'b0);
    chk32("ar_instr", ifa.instr_o, 32'h0);
    chk32("ar_pc", ifa.pc_o, 32'h0);
    chk32("ar_addr", ifa.imem_addr_o, 32'h0);
    $display("[TB] async reset mid-WAIT");
    tick();

    // RESET_PC at the top of the address space wraps to zero
    rstb_n = 1'b1;
    tick();
    chk1 ("wrap_req", ifb.imem_req_o, 1'b1);
    chk32("wrap_addr0", ifb.imem_addr_o, 32'hFFFF_FFFC);
    ifb.imem_gnt_i = 1'b1;
    tick();
    ifb.imem_gnt_i    = 1'b0;
    ifb.imem_rvalid_i = 1'b1;
    ifb.imem_rdata_i  = 32'h0000_006F;
    tick();
    ifb.imem_rvalid_i = 1'b0;
    chk1 ("wrap_valid", ifb.instr_valid_o, 1'b1);
    chk32("wrap_pc", ifb.pc_o, 32'hFFFF_FFFC);
    chk32("wrap_instr", ifb.instr_o, 32'h0000_006F);
    tick();
    chk1 ("wrap_req2", ifb.imem_req_o, 1'b1);
    chk32("wrap_addr1", ifb.imem_addr_o, 32'h0000_0000);
    $display("[TB] RESET_PC fffffffc wraps to 00000000");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
